// File: rtl/cpu_step_controller_pkg.sv
// Shared constants for the CPU step controller: FSM state encodings (also the
// LED debug encoding) and the default step-button debounce length.
package cpu_step_controller_pkg;

  localparam logic [1:0] StIdle        = 2'b00;
  localparam logic [1:0] StPulse       = 2'b01;
  localparam logic [1:0] StWaitRelease = 2'b10;
  localparam logic [1:0] StRun         = 2'b11;

  // 25 ms at 100 MHz; far shorter than the 250 ms reset debounce.
  localparam int unsigned DefaultDebounceCycles = 2_500_000;

endpackage

// File: rtl/cpu_step_controller_step_debouncer.sv
// step_debouncer: 2-flop synchroniser, stable-count debounce and rising-edge
// detector for the raw step push-button.
module step_debouncer
  import cpu_step_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned DEBOUNCE_WIDTH  = 32
) (
  input  logic clk,
  input  logic rstb,
  input  logic button_i,
  output logic debounced_o,
  output logic step_req_o
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CntMax = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]                sync_q;
  logic                      deb_q, deb_d;
  logic                      deb_dly_q;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], button_i};
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign debounced_o = deb_q;
  assign step_req_o  = deb_q & ~deb_dly_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Datapath clock-enable generator: one pulse per debounced press or a divided
// continuous rate in run mode. Define CPU_STEP_COUNT_EN to build the step counter.
module cpu_step_controller
  import cpu_step_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned DEBOUNCE_WIDTH  = 32,
  parameter int unsigned RUN_DIV         = 1,
  parameter int unsigned RUN_DIV_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        step_button,
  input  logic        run_mode,
  input  logic        halt,
  output logic        cpu_ena,
  output logic [31:0] step_count,
  output logic [1:0]  state_led
);

  localparam logic [RUN_DIV_WIDTH-1:0] DivMax = RUN_DIV_WIDTH'(RUN_DIV - 1);

  logic                     debounced;
  logic                     step_req;
  logic [1:0]               run_sync_q;
  logic [1:0]               state_q, state_d;
  logic [RUN_DIV_WIDTH-1:0] div_q, div_d;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
  ) u_step_debouncer (
    .clk        (clk),
    .rstb       (rstb),
    .button_i   (step_button),
    .debounced_o(debounced),
    .step_req_o (step_req)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    case (state_q)
      StIdle: begin
        // Run wins over a coincident step request.
        if (run_sync_q[1] && !halt) begin
          state_d = StRun;
        end else if (step_req && !halt) begin
          state_d = StPulse;
        end
      end
      StPulse: state_d = StWaitRelease;
      StWaitRelease: begin
        if (!debounced) state_d = StIdle;
      end
      default: begin
        if (!run_sync_q[1] || halt) begin
          state_d = StIdle;
          div_d   = '0;
        end else begin
          div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      run_sync_q <= '0;
      state_q    <= StIdle;
      div_q      <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], run_mode};
      state_q    <= state_d;
      div_q      <= div_d;
    end
  end

  assign cpu_ena   = (state_q == StPulse) | ((state_q == StRun) & (div_q == DivMax) & ~halt);
  assign state_led = state_q;

`ifdef CPU_STEP_COUNT_EN
  logic [31:0] step_count_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      step_count_q <= '0;
    end else if (cpu_ena) begin
      step_count_q <= step_count_q + 32'd1;
    end
  end

  assign step_count = step_count_q;
`else
  assign step_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: dut uses RUN_DIV=3, dut1 RUN_DIV=1,
// both with DEBOUNCE_CYCLES=4 and shared stimulus.
module tb_cpu_step_controller;

`ifdef CPU_STEP_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb, step_button, run_mode, halt;
  logic        cpu_ena, cpu_ena1;
  logic [31:0] step_count, step_count1;
  logic [1:0]  state_led, state_led1;

  int n_vec = 0;
  int n_err = 0;
  int exp_steps = 0;

  always #5 clk = ~clk;

  cpu_step_controller #(
    .DEBOUNCE_CYCLES(4), .DEBOUNCE_WIDTH(32), .RUN_DIV(3), .RUN_DIV_WIDTH(32)
  ) dut (
    .clk(clk), .rstb(rstb), .step_button(step_button), .run_mode(run_mode), .halt(halt),
    .cpu_ena(cpu_ena), .step_count(step_count), .state_led(state_led)
  );

  cpu_step_controller #(
    .DEBOUNCE_CYCLES(4), .DEBOUNCE_WIDTH(32), .RUN_DIV(1), .RUN_DIV_WIDTH(32)
  ) dut1 (
    .clk(clk), .rstb(rstb), .step_button(step_button), .run_mode(run_mode), .halt(halt),
    .cpu_ena(cpu_ena1), .step_count(step_count1), .state_led(state_led1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds the button 20 cycles then releases for 10, returning dut pulses seen.
  task automatic press(output int pulses);
    pulses = 0;
    step_button = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); pulses += int'(cpu_ena); end
    step_button = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); pulses += int'(cpu_ena); end
  endtask

  task automatic test_reset();
    int pulses;
    rstb = 1'b0; step_button = 1'b1; run_mode = 1'b0; halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (cpu_ena !== 1'b0) begin n_err++; $display("FAIL rst_ena: got %b want 0", cpu_ena); end
      n_vec++;
      if (step_count !== 32'd0) begin
        n_err++; $display("FAIL rst_count: got %0h want 0", step_count);
      end
      n_vec++;
      if (state_led !== 2'b00) begin n_err++; $display("FAIL rst_led: got %b want 00", state_led); end
    end
    rstb = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(); pulses += int'(cpu_ena); end
    step_button = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); pulses += int'(cpu_ena); end
    exp_steps = 1;
    n_vec++;
    if (pulses != 1) begin n_err++; $display("FAIL rst_held_pulses: got %0d want 1", pulses); end
    n_vec++;
    if (state_led !== 2'b00) begin n_err++; $display("FAIL rst_idle: got %b want 00", state_led); end
  endtask

  task automatic test_clean_press();
    logic [1:0] exp_led;
    step_button = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_led = (i < 7) ? 2'b00 : (i == 7) ? 2'b01 : 2'b10;
      n_vec++;
      if (cpu_ena !== (i == 7)) begin
        n_err++; $display("FAIL press_ena[%0d]: got %b want %b", i, cpu_ena, (i == 7));
      end
      n_vec++;
      if (state_led !== exp_led) begin
        n_err++; $display("FAIL press_led[%0d]: got %b want %b", i, state_led, exp_led);
      end
    end
    step_button = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_led = (i < 7) ? 2'b10 : 2'b00;
      n_vec++;
      if (state_led !== exp_led || cpu_ena !== 1'b0) begin
        n_err++;
        $display("FAIL release[%0d]: got led %b ena %b want led %b ena 0", i, state_led, cpu_ena,
                 exp_led);
      end
    end
    exp_steps = 2;
    n_vec++;
    if (step_count !== (CntEn ? 32'(exp_steps) : 32'd0)) begin
      n_err++; $display("FAIL press_count: got %0d want %0d", step_count, CntEn ? exp_steps : 0);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step_button = ((i / 2) % 2 == 0);
      tick();
      pulses += int'(cpu_ena);
    end
    n_vec++;
    if (pulses != 0) begin n_err++; $display("FAIL bounce_quiet: got %0d want 0", pulses); end
    press(pulses);
    exp_steps = 3;
    n_vec++;
    if (pulses != 1) begin n_err++; $display("FAIL bounce_hold: got %0d want 1", pulses); end
    n_vec++;
    if (step_count !== (CntEn ? 32'(exp_steps) : 32'd0)) begin
      n_err++; $display("FAIL bounce_count: got %0d want %0d", step_count, CntEn ? exp_steps : 0);
    end
  endtask

  task automatic test_run_mode();
    int  pulses;
    logic exp;
    pulses = 0;
    run_mode = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = (i >= 5) && ((i - 5) % 3 == 0);
      pulses += int'(cpu_ena);
      n_vec++;
      if (cpu_ena !== exp) begin
        n_err++; $display("FAIL run3_ena[%0d]: got %b want %b", i, cpu_ena, exp);
      end
      n_vec++;
      if (cpu_ena1 !== (i >= 3)) begin
        n_err++; $display("FAIL run1_ena[%0d]: got %b want %b", i, cpu_ena1, (i >= 3));
      end
    end
    n_vec++;
    if (pulses != 9) begin n_err++; $display("FAIL run3_pulses: got %0d want 9", pulses); end
    run_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(cpu_ena); end
    n_vec++;
    if (state_led !== 2'b00 || state_led1 !== 2'b00) begin
      n_err++; $display("FAIL run_exit: got %b/%b want 00/00", state_led, state_led1);
    end
    exp_steps = 13;
    n_vec++;
    if (pulses != 10) begin n_err++; $display("FAIL run3_total: got %0d want 10", pulses); end
    n_vec++;
    if (step_count !== (CntEn ? 32'(exp_steps) : 32'd0)) begin
      n_err++; $display("FAIL run_count: got %0d want %0d", step_count, CntEn ? exp_steps : 0);
    end
  endtask

  task automatic test_halt();
    int pulses;
    run_mode = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (cpu_ena1 !== 1'b1 || state_led1 !== 2'b11) begin
      n_err++; $display("FAIL halt_pre: got ena %b led %b want 1 11", cpu_ena1, state_led1);
    end
    halt = 1'b1;
    #1;
    n_vec++;
    if (cpu_ena1 !== 1'b0 || state_led1 !== 2'b11) begin
      n_err++; $display("FAIL halt_same: got ena %b led %b want 0 11", cpu_ena1, state_led1);
    end
    tick();
    n_vec++;
    if (state_led1 !== 2'b00 || state_led !== 2'b00) begin
      n_err++; $display("FAIL halt_next: got %b/%b want 00/00", state_led1, state_led);
    end
    press(pulses);
    n_vec++;
    if (pulses != 0 || state_led !== 2'b00) begin
      n_err++; $display("FAIL halt_press: got %0d pulses led %b want 0 00", pulses, state_led);
    end
    run_mode = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    halt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (cpu_ena !== 1'b0 || state_led !== 2'b00) begin
      n_err++; $display("FAIL halt_exit: got ena %b led %b want 0 00", cpu_ena, state_led);
    end
    n_vec++;
    if (step_count !== (CntEn ? 32'(exp_steps) : 32'd0)) begin
      n_err++; $display("FAIL halt_count: got %0d want %0d", step_count, CntEn ? exp_steps : 0);
    end
  endtask

  task automatic test_count();
    int pulses, total;
`ifdef CPU_STEP_COUNT_EN
    force dut.step_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.step_count_q;
    tick();
    n_vec++;
    if (step_count !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL wrap_pre: got %0h want ffffffff", step_count);
    end
    press(pulses);
    n_vec++;
    if (pulses != 1 || step_count !== 32'd0) begin
      n_err++; $display("FAIL wrap: got %0d pulses count %0h want 1 0", pulses, step_count);
    end
`else
    total = 0;
    for (int s = 0; s < 5; s++) begin press(pulses); total += pulses; end
    n_vec++;
    if (total != 5) begin n_err++; $display("FAIL five_steps: got %0d want 5", total); end
    n_vec++;
    if (step_count !== 32'd0) begin
      n_err++; $display("FAIL tied_count: got %0h want 0", step_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_run_mode();
    test_halt();
    test_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
